uart_rx_frame_ctrl: RTL

Frame controller that sits directly behind the UART receive path. It consumes the byte stream (data byte plus one-cycle done strobe) and sequences it through a fixed frame format: header, command, length, payload, checksum. The payload goes into an internal buffer. A validated frame is held for the consumer until it is acknowledged; malformed, timed-out or overrunning traffic is reported and discarded.

---
 rtl/uart_rx_frame_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: HEADER, CMD, LEN, PAYLOAD, CHK framing with a payload buffer and hold-until-ack.
// Optional saturating frame counters are enabled with the RX_FRAME_STATS_EN macro.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER         = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         PL_AW          = 4,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_done,
  output logic             frame_ready,
  output logic [7:0]       frame_cmd,
  output logic [7:0]       frame_len,
  input  logic [PL_AW-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic             frame_ack,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             byte_drop,
  output logic             busy,
  output logic [15:0]      good_cnt,
  output logic [15:0]      err_cnt,
  output logic [2:0]       state_o
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_sh_q, cmd_sh_d, len_sh_q, len_sh_d;
  logic [7:0]    fcmd_q, fcmd_d, flen_q, flen_d;
  logic [7:0]    sum_q, sum_d, idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d, drop_q, drop_d;
  logic [1:0]    code_q, code_d;
  logic          wr_en;
  logic          in_frame;
  logic [7:0]    mem [2**PL_AW];

  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAY) || (state_q == S_CHK);

  always_comb begin
    state_d  = state_q;
    cmd_sh_d = cmd_sh_q;
    len_sh_d = len_sh_q;
    fcmd_d   = fcmd_q;
    flen_d   = flen_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    code_d   = code_q;
    drop_d   = 1'b0;
    wr_en    = 1'b0;
    // Idle-gap watchdog; a byte in the expiry cycle overrides it below.
    if (in_frame) begin
      if (uart_rx_done) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        code_d  = 2'd3;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (uart_rx_done) begin
      case (state_q)
        S_IDLE: if (uart_rx_data == HEADER) begin
          state_d = S_CMD;
          sum_d   = 8'h00;
        end
        S_CMD: begin
          cmd_sh_d = uart_rx_data;
          sum_d    = uart_rx_data;
          state_d  = S_LEN;
        end
        S_LEN: begin
          if (uart_rx_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
          end else begin
            len_sh_d = uart_rx_data;
            sum_d    = sum_q + uart_rx_data;
            idx_d    = 8'h00;
            state_d  = (uart_rx_data == 8'h00) ? S_CHK : S_PAY;
          end
        end
        S_PAY: begin
          wr_en = 1'b1;
          sum_d = sum_q + uart_rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_sh_q - 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (uart_rx_data == sum_q) begin
            fcmd_d  = cmd_sh_q;
            flen_d  = len_sh_q;
            state_d = S_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_IDLE;
          end
        end
        S_HOLD: drop_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_q == S_HOLD && frame_ack) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_sh_q <= 8'h00;
      len_sh_q <= 8'h00;
      fcmd_q   <= 8'h00;
      flen_q   <= 8'h00;
      sum_q    <= 8'h00;
      idx_q    <= 8'h00;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_sh_q <= cmd_sh_d;
      len_sh_q <= len_sh_d;
      fcmd_q   <= fcmd_d;
      flen_q   <= flen_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      code_q   <= code_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage has no reset; only the read register does.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[idx_q[PL_AW-1:0]] <= uart_rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end

`ifdef RX_FRAME_STATS_EN
  logic [15:0] good_q, bad_q;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= 16'h0000;
      bad_q  <= 16'h0000;
    end else begin
      if (state_q != S_HOLD && state_d == S_HOLD && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if (err_d && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end
  assign good_cnt = good_q;
  assign err_cnt  = bad_q;
`else
  assign good_cnt = 16'h0000;
  assign err_cnt  = 16'h0000;
`endif

  assign frame_ready = (state_q == S_HOLD);
  assign frame_cmd   = fcmd_q;
  assign frame_len   = flen_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign byte_drop   = drop_q;
  assign busy        = in_frame;
  assign state_o     = state_q;
endmodule
